fb_write_arbiter: RTL and testbench
===================================

Name: fb_write_arbiter

Overview:
- Shares the single frame-buffer write port between two pixel streams: the composite image stream (IM, pre-addressed) and the object overlay stream (OBJ, X/Y coordinates).
- Converts OBJ coordinates to a linear address (X + Y*H_RES).
- Drops object pixels that are off-screen or transparent.
- Arbitrates round-robin when both streams are valid, and drives one registered frame-buffer write per accepted pixel with backpressure.

Parameters:
- H_RES, 640, horizontal resolution; the OBJ address multiplier.
- V_RES, 480, vertical resolution; OBJ_Y bound.
- TRANSP_EN, 1, enables dropping of OBJ pixels equal to TRANSP_KEY.
- TRANSP_KEY, 8'h00, transparent colour code for OBJ pixels.

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- FRAME_SYNC  in  1  one-cycle pulse at frame start; synchronous clear.
- IM_VALID  in  1  IM pixel available.
- IM_DATA  in  8  IM pixel colour.
- IM_ADDR  in  19  IM linear frame-buffer address.
- IM_READY  out  1  IM pixel consumed this cycle.
- OBJ_VALID  in  1  OBJ pixel available.
- OBJ_DATA  in  8  OBJ pixel colour.
- OBJ_X  in  10  OBJ column.
- OBJ_Y  in  10  OBJ row.
- OBJ_READY  out  1  OBJ pixel consumed this cycle.
- FB_WE  out  1  write request to the frame buffer.
- FB_ADDR  out  19  write address.
- FB_DATA  out  8  write data.
- FB_READY  in  1  frame buffer accepts the write this cycle.
- DROP_CNT  out  16  OBJ pixels discarded this frame; saturating.

Behaviour:
- Reset (RESET low, async):
  - FB_WE=0, FB_ADDR=0, FB_DATA=0, DROP_CNT=0, last_gnt=OBJ, so IM wins the first contest.
  - A pending write is discarded, not replayed.
- Output register:
  - can_load = !FB_WE || FB_READY.
  - A write presented with FB_WE=1 holds ADDR and DATA stable until FB_READY is sampled high.
- Selection (combinational, each cycle):
  - Only IM_VALID: sel=IM.
  - Only OBJ_VALID: sel=OBJ.
  - Both valid: sel is the opposite of last_gnt.
  - Neither valid: no selection.
- Handshake:
  - IM_READY = can_load && IM_VALID && sel==IM.
  - OBJ_READY = can_load && OBJ_VALID && sel==OBJ.
  - At most one READY is high per cycle. A transfer is VALID&&READY at a rising edge.
- On IM transfer at edge N:
  - FB_WE=1, FB_ADDR=IM_ADDR, FB_DATA=IM_DATA, visible after edge N.
  - last_gnt=IM.
- On OBJ transfer at edge N:
  - addr = OBJ_X + OBJ_Y*H_RES, computed in 19 bits; no overflow within range (max 307199).
  - drop = (OBJ_X>=H_RES) || (OBJ_Y>=V_RES) || (TRANSP_EN && OBJ_DATA==TRANSP_KEY).
  - If !drop: FB_WE=1, FB_ADDR=addr, FB_DATA=OBJ_DATA.
  - If drop: the pixel is consumed anyway. FB_WE = 0 if the old write retired (FB_READY) or none was pending. DROP_CNT increments, saturating at 16'hFFFF.
  - last_gnt=OBJ in both cases.
- No transfer and FB_READY while FB_WE=1: FB_WE goes to 0. ADDR and DATA hold their last value.
- Throughput: one write per cycle when FB_READY is held high (back-to-back).
- Latency: 1 cycle from transfer to FB_WE.
- FRAME_SYNC (sync):
  - DROP_CNT clears to 0 and last_gnt resets to OBJ.
  - If a drop occurs in the same cycle, DROP_CNT = 1; the clear takes effect first, then the increment.
  - The FB output register and any pending write are unaffected.
- Fairness: under continuous dual validity with FB_READY=1, grants alternate IM,OBJ,IM,OBJ…
- FB_READY while FB_WE=0 is ignored.

Decomposition:
- Package fb_pkg:
  - H_RES/V_RES defaults.
  - FB_ADDR_W=19, PIX_W=8, COORD_W=10.
  - gnt_t enum {GNT_IM, GNT_OBJ}.
- Sub-module fb_addr_calc, combinational:
  - (OBJ_X, OBJ_Y) -> addr and in_range.
  - Implemented as (Y<<9)+(Y<<7)+X when H_RES=640; generic multiply otherwise.

Test Plan:
- Reset: RESET low mid-write (FB_WE=1, FB_READY=0) -> FB_WE=0, ADDR=0, DATA=0, DROP_CNT=0 immediately (async). After release, the first contest is granted to IM.
- OBJ address: OBJ_X=639, OBJ_Y=479, DATA=8'h5A, FB_READY=1 -> next cycle FB_WE=1, FB_ADDR=307199, FB_DATA=8'h5A. X=0,Y=1 -> ADDR=640.
- Round robin: both streams valid for 6 cycles with FB_READY=1 -> grants IM,OBJ,IM,OBJ,IM,OBJ; FB_WE high all 6 cycles after the first.
- Backpressure: FB_READY=0 for 3 cycles with a write pending -> IM_READY=OBJ_READY=0, FB_ADDR/DATA stable. FB_READY=1 -> the next pixel loads the same edge.
- Drops: OBJ pixels (640,0), (0,480) and (5,5) with DATA=8'h00 -> all three consumed (OBJ_READY), no FB_WE, DROP_CNT=3. FRAME_SYNC -> DROP_CNT=0.
- Saturation: 65540 transparent OBJ pixels -> DROP_CNT=16'hFFFF, no wrap.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and widths for the frame-buffer write path.
// Imported by the arbiter and its address calculator.
package fb_pkg;

    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;

    localparam int FB_ADDR_W = 19;
    localparam int PIX_W     = 8;
    localparam int COORD_W   = 10;

    typedef enum logic {
        GNT_IM  = 1'b0,
        GNT_OBJ = 1'b1
    } gnt_t;

endpackage

// File: rtl/fb_addr_calc.sv
// Object coordinate to linear frame-buffer address, plus on-screen test.
// Purely combinational.
import fb_pkg::*;

module fb_addr_calc #(
    parameter int H_RES = H_RES_DEF,
    parameter int V_RES = V_RES_DEF
) (
    input  logic [COORD_W-1:0]   i_x,
    input  logic [COORD_W-1:0]   i_y,
    output logic [FB_ADDR_W-1:0] o_addr,
    output logic                 o_in_range
);

    localparam logic [COORD_W:0] HR = (COORD_W+1)'(H_RES);
    localparam logic [COORD_W:0] VR = (COORD_W+1)'(V_RES);

    logic [FB_ADDR_W-1:0] w_x19;
    logic [FB_ADDR_W-1:0] w_y19;

    assign w_x19 = {{(FB_ADDR_W-COORD_W){1'b0}}, i_x};
    assign w_y19 = {{(FB_ADDR_W-COORD_W){1'b0}}, i_y};

    // 640 = 512 + 128, so the common case needs only shifts and adds
    generate
        if (H_RES == 640) begin : g_shift
            assign o_addr = (w_y19 << 9) + (w_y19 << 7) + w_x19;
        end else begin : g_mult
            localparam logic [FB_ADDR_W-1:0] HM = FB_ADDR_W'(H_RES);
            assign o_addr = (w_y19 * HM) + w_x19;
        end
    endgenerate

    assign o_in_range = ({1'b0, i_x} < HR) && ({1'b0, i_y} < VR);

endmodule

// File: rtl/fb_write_arbiter.sv
// Round-robin merge of the image and object pixel streams onto the
// single frame-buffer write port, with a registered, backpressured output.
import fb_pkg::*;

module fb_write_arbiter #(
    parameter int               H_RES      = H_RES_DEF,
    parameter int               V_RES      = V_RES_DEF,
    parameter bit               TRANSP_EN  = 1'b1,
    parameter logic [PIX_W-1:0] TRANSP_KEY = 8'h00
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET,
    input  logic                 FRAME_SYNC,
    input  logic                 IM_VALID,
    input  logic [PIX_W-1:0]     IM_DATA,
    input  logic [FB_ADDR_W-1:0] IM_ADDR,
    output logic                 IM_READY,
    input  logic                 OBJ_VALID,
    input  logic [PIX_W-1:0]     OBJ_DATA,
    input  logic [COORD_W-1:0]   OBJ_X,
    input  logic [COORD_W-1:0]   OBJ_Y,
    output logic                 OBJ_READY,
    output logic                 FB_WE,
    output logic [FB_ADDR_W-1:0] FB_ADDR,
    output logic [PIX_W-1:0]     FB_DATA,
    input  logic                 FB_READY,
    output logic [15:0]          DROP_CNT
);

    logic                 r_we;
    logic [FB_ADDR_W-1:0] r_addr;
    logic [PIX_W-1:0]     r_data;
    logic [15:0]          r_drop_cnt;
    gnt_t                 r_last_gnt;

    logic                 w_can_load;
    logic                 w_sel_im;
    logic                 w_sel_obj;
    logic                 w_im_xfer;
    logic                 w_obj_xfer;
    logic [FB_ADDR_W-1:0] w_obj_addr;
    logic                 w_obj_in_range;
    logic                 w_obj_transp;
    logic                 w_obj_drop;
    logic [15:0]          w_cnt_base;
    logic [15:0]          w_cnt_next;

    fb_addr_calc #(
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) u_addr_calc (
        .i_x        (OBJ_X),
        .i_y        (OBJ_Y),
        .o_addr     (w_obj_addr),
        .o_in_range (w_obj_in_range)
    );

    assign w_can_load = !r_we || FB_READY;

    // On contention, the stream that did not win last time goes first
    assign w_sel_im  = IM_VALID &&
                       (!OBJ_VALID || (r_last_gnt == GNT_OBJ));
    assign w_sel_obj = OBJ_VALID &&
                       (!IM_VALID || (r_last_gnt == GNT_IM));

    assign w_im_xfer  = w_can_load && w_sel_im;
    assign w_obj_xfer = w_can_load && w_sel_obj;

    assign w_obj_transp = TRANSP_EN && (OBJ_DATA == TRANSP_KEY);
    assign w_obj_drop   = !w_obj_in_range || w_obj_transp;

    // Frame clear is applied before the same-cycle drop increment
    assign w_cnt_base = FRAME_SYNC ? 16'd0 : r_drop_cnt;

    always_comb begin
        w_cnt_next = w_cnt_base;
        if (w_obj_xfer && w_obj_drop && (w_cnt_base != 16'hFFFF))
            w_cnt_next = w_cnt_base + 16'd1;
    end

    always_ff @(posedge CLOCK_50 or negedge RESET) begin
        if (!RESET) begin
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_drop_cnt <= '0;
            r_last_gnt <= GNT_OBJ;
        end else begin
            r_drop_cnt <= w_cnt_next;
            if (w_im_xfer) begin
                r_we       <= 1'b1;
                r_addr     <= IM_ADDR;
                r_data     <= IM_DATA;
                r_last_gnt <= GNT_IM;
            end else if (w_obj_xfer) begin
                r_last_gnt <= GNT_OBJ;
                // can_load guarantees any old write has retired here
                r_we       <= !w_obj_drop;
                if (!w_obj_drop) begin
                    r_addr <= w_obj_addr;
                    r_data <= OBJ_DATA;
                end
            end else if (FB_READY) begin
                r_we <= 1'b0;
            end
            if (FRAME_SYNC)
                r_last_gnt <= GNT_OBJ;
        end
    end

    assign IM_READY  = w_im_xfer;
    assign OBJ_READY = w_obj_xfer;
    assign FB_WE     = r_we;
    assign FB_ADDR   = r_addr;
    assign FB_DATA   = r_data;
    assign DROP_CNT  = r_drop_cnt;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Randomized and directed bench for fb_write_arbiter against a
// transaction-level model of the write port.
module tb_fb_write_arbiter;

    logic        CLOCK_50;
    logic        RESET;
    logic        FRAME_SYNC;
    logic        IM_VALID;
    logic [7:0]  IM_DATA;
    logic [18:0] IM_ADDR;
    logic        IM_READY;
    logic        OBJ_VALID;
    logic [7:0]  OBJ_DATA;
    logic [9:0]  OBJ_X;
    logic [9:0]  OBJ_Y;
    logic        OBJ_READY;
    logic        FB_WE;
    logic [18:0] FB_ADDR;
    logic [7:0]  FB_DATA;
    logic        FB_READY;
    logic [15:0] DROP_CNT;

    fb_write_arbiter dut (
        .CLOCK_50   (CLOCK_50),
        .RESET      (RESET),
        .FRAME_SYNC (FRAME_SYNC),
        .IM_VALID   (IM_VALID),
        .IM_DATA    (IM_DATA),
        .IM_ADDR    (IM_ADDR),
        .IM_READY   (IM_READY),
        .OBJ_VALID  (OBJ_VALID),
        .OBJ_DATA   (OBJ_DATA),
        .OBJ_X      (OBJ_X),
        .OBJ_Y      (OBJ_Y),
        .OBJ_READY  (OBJ_READY),
        .FB_WE      (FB_WE),
        .FB_ADDR    (FB_ADDR),
        .FB_DATA    (FB_DATA),
        .FB_READY   (FB_READY),
        .DROP_CNT   (DROP_CNT)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = !CLOCK_50;

    int n_chk;
    int n_pass;
    bit quiet;

    // Reference view of the write port
    bit m_we;
    int m_addr;
    int m_data;
    int m_cnt;
    bit m_last_obj;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_we = 0;
        m_addr = 0;
        m_data = 0;
        m_cnt = 0;
        m_last_obj = 1;
    endtask

    task automatic idle_inputs();
        FRAME_SYNC = 0;
        IM_VALID = 0;
        IM_DATA = 0;
        IM_ADDR = 0;
        OBJ_VALID = 0;
        OBJ_DATA = 0;
        OBJ_X = 0;
        OBJ_Y = 0;
    endtask

    // Called #1 after a rising edge with the inputs already driven
    task automatic cycle();
        bit can, gi, go, drop;
        int a;
        #2;
        can = !m_we || FB_READY;
        gi = 0;
        go = 0;
        if (IM_VALID && OBJ_VALID) begin
            if (m_last_obj) gi = 1;
            else go = 1;
        end else if (IM_VALID) gi = 1;
        else if (OBJ_VALID) go = 1;
        gi = gi && can;
        go = go && can;
        if (!quiet) begin
            chk("im_ready", 32'(IM_READY), 32'(gi));
            chk("obj_ready", 32'(OBJ_READY), 32'(go));
        end
        a = int'(OBJ_X) + int'(OBJ_Y) * 640;
        drop = (OBJ_X >= 640) || (OBJ_Y >= 480) || (OBJ_DATA == 0);
        if (FRAME_SYNC) m_cnt = 0;
        if (gi) begin
            m_we = 1;
            m_addr = int'(IM_ADDR);
            m_data = int'(IM_DATA);
            m_last_obj = 0;
        end else if (go) begin
            m_last_obj = 1;
            if (drop) begin
                m_we = 0;
                if (m_cnt < 65535) m_cnt++;
            end else begin
                m_we = 1;
                m_addr = a;
                m_data = int'(OBJ_DATA);
            end
        end else if (FB_READY) begin
            m_we = 0;
        end
        if (FRAME_SYNC) m_last_obj = 1;
        @(posedge CLOCK_50);
        #1;
        if (!quiet) begin
            chk("fb_we", 32'(FB_WE), 32'(m_we));
            chk("fb_addr", 32'(FB_ADDR), 32'(m_addr));
            chk("fb_data", 32'(FB_DATA), 32'(m_data));
            chk("drop_cnt", 32'(DROP_CNT), 32'(m_cnt));
        end
    endtask

    logic [18:0] held_addr;
    logic [7:0]  held_data;

    initial begin
        n_chk = 0;
        n_pass = 0;
        quiet = 0;
        RESET = 0;
        FB_READY = 0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge CLOCK_50);
        #1;
        RESET = 1;
        chk("rst_we", 32'(FB_WE), 32'd0);
        chk("rst_cnt", 32'(DROP_CNT), 32'd0);

        // One drop, then a write left pending, then async reset
        OBJ_VALID = 1; OBJ_X = 5; OBJ_Y = 5; OBJ_DATA = 8'h00;
        FB_READY = 1;
        cycle();
        idle_inputs();
        IM_VALID = 1; IM_ADDR = 19'd123; IM_DATA = 8'h77;
        FB_READY = 0;
        cycle();
        idle_inputs();
        chk("pend_we", 32'(FB_WE), 32'd1);
        #5;
        RESET = 0;
        #1;
        chk("arst_we", 32'(FB_WE), 32'd0);
        chk("arst_addr", 32'(FB_ADDR), 32'd0);
        chk("arst_data", 32'(FB_DATA), 32'd0);
        chk("arst_cnt", 32'(DROP_CNT), 32'd0);
        model_reset();
        #3;
        RESET = 1;
        @(posedge CLOCK_50);
        #1;
        IM_VALID = 1; IM_ADDR = 19'd9; IM_DATA = 8'h11;
        OBJ_VALID = 1; OBJ_X = 1; OBJ_Y = 1; OBJ_DATA = 8'h22;
        FB_READY = 1;
        #1;
        chk("first_im", 32'(IM_READY), 32'd1);
        chk("first_obj", 32'(OBJ_READY), 32'd0);
        cycle();

        // Address conversion corners
        idle_inputs();
        OBJ_VALID = 1; OBJ_X = 639; OBJ_Y = 479; OBJ_DATA = 8'h5A;
        cycle();
        chk("corner_we", 32'(FB_WE), 32'd1);
        chk("corner_addr", 32'(FB_ADDR), 32'd307199);
        chk("corner_data", 32'(FB_DATA), 32'h5A);
        OBJ_X = 0; OBJ_Y = 1;
        cycle();
        chk("row1_addr", 32'(FB_ADDR), 32'd640);

        // Round robin from a freshly synced arbiter
        idle_inputs();
        FRAME_SYNC = 1;
        cycle();
        FRAME_SYNC = 0;
        for (int i = 0; i < 6; i++) begin
            IM_VALID = 1; IM_ADDR = 19'(100 + i); IM_DATA = 8'(8'h30 + i);
            OBJ_VALID = 1; OBJ_X = 10'(i); OBJ_Y = 2; OBJ_DATA = 8'(8'h40 + i);
            #1;
            chk("rr_im", 32'(IM_READY), 32'(i % 2 == 0));
            cycle();
            chk("rr_we", 32'(FB_WE), 32'd1);
        end

        // Backpressure holds the output register
        idle_inputs();
        IM_VALID = 1; IM_ADDR = 19'd4321; IM_DATA = 8'hC3;
        cycle();
        held_addr = FB_ADDR;
        held_data = FB_DATA;
        FB_READY = 0;
        IM_ADDR = 19'd999; IM_DATA = 8'h99;
        OBJ_VALID = 1; OBJ_X = 3; OBJ_Y = 3; OBJ_DATA = 8'h12;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_addr", 32'(FB_ADDR), 32'(held_addr));
            chk("bp_data", 32'(FB_DATA), 32'(held_data));
        end
        FB_READY = 1;
        #1;
        chk("bp_release", 32'(IM_READY | OBJ_READY), 32'd1);
        cycle();

        // Off-screen and transparent object pixels
        idle_inputs();
        FRAME_SYNC = 1;
        cycle();
        FRAME_SYNC = 0;
        OBJ_VALID = 1; OBJ_DATA = 8'h00;
        for (int i = 0; i < 3; i++) begin
            OBJ_X = (i == 0) ? 10'd640 : (i == 1) ? 10'd0 : 10'd5;
            OBJ_Y = (i == 0) ? 10'd0 : (i == 1) ? 10'd480 : 10'd5;
            OBJ_DATA = (i == 2) ? 8'h00 : 8'h7E;
            #1;
            chk("drop_rdy", 32'(OBJ_READY), 32'd1);
            cycle();
            chk("drop_we", 32'(FB_WE), 32'd0);
        end
        chk("drop_three", 32'(DROP_CNT), 32'd3);
        idle_inputs();
        FRAME_SYNC = 1;
        cycle();
        chk("sync_clear", 32'(DROP_CNT), 32'd0);
        FRAME_SYNC = 1;
        OBJ_VALID = 1; OBJ_X = 1; OBJ_Y = 1; OBJ_DATA = 8'h00;
        cycle();
        chk("sync_plus_drop", 32'(DROP_CNT), 32'd1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            FRAME_SYNC = ($urandom_range(0, 49) == 0);
            IM_VALID = $urandom_range(0, 1) == 1;
            IM_ADDR = 19'($urandom_range(0, 307199));
            IM_DATA = 8'($urandom);
            OBJ_VALID = $urandom_range(0, 1) == 1;
            OBJ_X = 10'($urandom_range(0, 700));
            OBJ_Y = 10'($urandom_range(0, 520));
            OBJ_DATA = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            FB_READY = $urandom_range(0, 9) < 7;
            cycle();
        end

        // Saturation
        idle_inputs();
        FRAME_SYNC = 1;
        FB_READY = 1;
        cycle();
        FRAME_SYNC = 0;
        OBJ_VALID = 1; OBJ_X = 7; OBJ_Y = 7; OBJ_DATA = 8'h00;
        quiet = 1;
        repeat (65540) cycle();
        quiet = 0;
        chk("sat_cnt", 32'(DROP_CNT), 32'h0000FFFF);
        cycle();
        chk("sat_hold", 32'(DROP_CNT), 32'h0000FFFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
